sseg_capture: RTL

Receive-side counterpart of the board's seven-segment drive path. It samples the multiplexed four-digit display lines: active-low anode selects plus active-low segments and decimal point. Each digit's pattern is debounced and decoded back to a BCD nibble. A complete four-digit frame is presented with a one-cycle valid strobe, for self-check and loopback of the banner display logic.

---
 rtl/sseg_pkg.sv | 47 ++++
 rtl/sseg_capture_if.sv | 25 ++
 rtl/sseg_pattern_decode.sv | 28 ++
 rtl/sseg_capture.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: segment bit order, digit patterns, anode mapping.
// Both the display encoder and this capture path use it, so the two sides cannot drift apart.
package sseg_pkg;

  // Bit order on the active-low sseg bus: dp on top, then a..g.
  localparam int SEG_DP_BIT = 7;
  localparam int SEG_A_BIT  = 6;
  localparam int SEG_G_BIT  = 0;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } dwell_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } an_sel_t;

  // One-hot-low anode to digit index; anything else is a blanking gap.
  function automatic an_sel_t an_to_idx(input logic [3:0] an_n);
    an_sel_t r;
    r = '0;
    case (an_n)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// Display-side pins in, decoded frame out, plus the dwell FSM state and seen mask for debug.
interface sseg_capture_if;
  import sseg_pkg::*;

  logic [3:0]   an_n;
  logic [7:0]   sseg;
  logic [15:0]  bcd_out;
  logic [3:0]   dp_out;
  logic [3:0]   err_out;
  logic         frame_valid;
  dwell_state_t dbg_state;
  logic [3:0]   dbg_seen;

  // frame_valid is a push-only strobe with no ready: bcd_out/dp_out/err_out change only
  // in the cycle it is high and hold otherwise, so a consumer must take the frame then.
  modport master (
    output an_n, sseg,
    input  bcd_out, dp_out, err_out, frame_valid, dbg_state, dbg_seen
  );

  modport slave (
    input  an_n, sseg,
    output bcd_out, dp_out, err_out, frame_valid, dbg_state, dbg_seen
  );
endinterface

// File: rtl/sseg_pattern_decode.sv
// Combinational 7-segment pattern (a..g, active-low) to BCD nibble with illegal-pattern flag.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'hF;
    err    = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Samples the multiplexed display lines, debounces each digit dwell, and assembles
// four captured digits into a frame with a one-cycle strobe.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  sseg_capture_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [3:0]  an_s1, an_s2, an_prev;
  logic [7:0]  seg_s1, seg_s2, seg_prev;

  dwell_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic        capture;
  logic        same;
  an_sel_t     sel;

  logic [3:0]  dec_nib;
  logic        dec_err;

  logic [3:0][3:0] slot_nib;
  logic [3:0]  slot_dp, slot_err;
  logic [3:0]  seen, seen_next;
  logic        all_seen;

  logic [15:0] bcd_q;
  logic [3:0]  dp_q, err_q;
  logic        fv_q;

  // Synchronizers and previous-sample register reset to a dark display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1    <= 4'hF;
      an_s2    <= 4'hF;
      an_prev  <= 4'hF;
      seg_s1   <= {1'b1, SEG_BLANK};
      seg_s2   <= {1'b1, SEG_BLANK};
      seg_prev <= {1'b1, SEG_BLANK};
    end else begin
      an_s1    <= bus.an_n;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= bus.sseg;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  assign sel  = an_to_idx(an_s2);
  assign same = ({an_s2, seg_s2} == {an_prev, seg_prev});

  sseg_pattern_decode u_decode (
    .pattern (seg_s2[SEG_A_BIT:SEG_G_BIT]),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel.valid) begin
          state_next = ST_SETTLE;
          cnt_next   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (same) begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            capture    = 1'b1;
            state_next = ST_HELD;
          end
        end else if (sel.valid) begin
          cnt_next = CNT_W'(1);
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_HELD: begin
        if (!same) begin
          if (sel.valid) begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_W'(1);
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      default: begin
        state_next = ST_WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign all_seen = &seen;

  // A capture on the frame-completion edge keeps its bit for the following frame.
  always_comb begin
    seen_next = all_seen ? 4'b0000 : seen;
    if (capture) seen_next[sel.idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_nib <= '0;
      slot_dp  <= '0;
      slot_err <= '0;
      seen     <= '0;
    end else begin
      seen <= seen_next;
      if (capture) begin
        slot_nib[sel.idx] <= dec_nib;
        slot_dp[sel.idx]  <= ~seg_s2[SEG_DP_BIT];
        slot_err[sel.idx] <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      dp_q  <= '0;
      err_q <= '0;
      fv_q  <= 1'b0;
    end else begin
      fv_q <= all_seen;
      if (all_seen) begin
        bcd_q <= slot_nib;
        dp_q  <= slot_dp;
        err_q <= slot_err;
      end
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.dp_out      = dp_q;
  assign bus.err_out     = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_seen    = seen;

endmodule
